// File: rtl/cp0_exc_unit_if.sv
// Pipeline-to-CP0 bundle: mtc0/mfc0 access, M-stage exception info and the flush/redirect outputs.
interface cp0_exc_unit_if;
  logic        WE;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] HandlerPC;
  logic [31:0] EPCOut;

  modport master (
    output WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, Req, HandlerPC, EPCOut
  );

  modport slave (
    input  WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, Req, HandlerPC, EPCOut
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, interrupt/exception arbitration,
// pipeline flush request and eret state restore.
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h2022_0707,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_unit_if.slave bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  excCode;
  logic [31:0] epc;

  logic [31:0] srWord;
  logic [31:0] causeWord;
  logic        intReq;
  logic        excReq;
  logic        req;

  assign srWord    = {16'b0, im, 8'b0, exl, ie};
  assign causeWord = {bd, 15'b0, ip, 3'b0, excCode, 2'b0};

  // Interrupts outrank exceptions; nothing is requested while already in a handler.
  assign intReq = (|(bus.HWInt & im)) & ie & ~exl;
  assign excReq = (bus.ExcCodeIn != 5'd0) & ~exl;
  assign req    = intReq | excReq;

  assign bus.Req       = req;
  assign bus.HandlerPC = HANDLER_PC;
  assign bus.EPCOut    = epc;

  // A taken request drops any same-cycle mtc0 since the faulting instruction never commits;
  // the eret clear comes last so it beats an mtc0 to SR for the EXL bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im      <= 6'd0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ip      <= 6'd0;
      excCode <= 5'd0;
      epc     <= 32'd0;
    end else begin
      ip <= bus.HWInt;
      if (req) begin
        exl     <= 1'b1;
        excCode <= intReq ? 5'd0 : bus.ExcCodeIn;
        bd      <= bus.BDIn;
        epc     <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
      end else begin
        if (bus.WE && (bus.CP0Addr == 5'd12)) begin
          im  <= bus.CP0In[15:10];
          exl <= bus.CP0In[1];
          ie  <= bus.CP0In[0];
        end
        if (bus.WE && (bus.CP0Addr == 5'd14)) begin
          epc <= bus.CP0In;
        end
        if (bus.EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.CP0Out = 32'd0;
    case (bus.CP0Addr)
      5'd12:   bus.CP0Out = srWord;
      5'd13:   bus.CP0Out = causeWord;
      5'd14:   bus.CP0Out = epc;
      5'd15:   bus.CP0Out = PRID;
      default: bus.CP0Out = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 block of the P7 pipelined MIPS core, sitting at the M stage.
- It is the consuming end of the exception flags that the execute-stage ALU and the other stages raise. Upstream, ALU arithmetic overflow is encoded as Ov (12) and ALU address overflow as AdEL (4) or AdES (5).
- It holds the SR, Cause, EPC and PRId registers and serves mfc0/mtc0.
- It arbitrates interrupts against exceptions, produces the pipeline flush/redirect request, and restores state on eret.

Parameters:
- PRID, 32'h2022_0707, read-only value returned for register 15.
- HANDLER_PC, 32'h0000_4180, redirect target presented on HandlerPC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- WE  input  1  mtc0 write enable (M stage).
- CP0Addr  input  5  register number for mtc0/mfc0.
- CP0In  input  32  mtc0 write data.
- CP0Out  output  32  mfc0 read data (combinational).
- VPC  input  32  PC of the M-stage instruction.
- BDIn  input  1  M-stage instruction is in a delay slot.
- ExcCodeIn  input  5  exception code from the pipeline; 0 means none.
- HWInt  input  6  external hardware interrupt lines.
- EXLClr  input  1  eret is in the M stage.
- Req  output  1  flush the pipeline and redirect to HandlerPC (combinational).
- HandlerPC  output  32  constant HANDLER_PC.
- EPCOut  output  32  current EPC register, used as the eret target.

Behaviour:
- State:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
- Reset, asynchronous:
  - SR, Cause and EPC become 0, so Req=0 and EPCOut=0 during reset.
  - Reset asserted mid-handler clears EXL immediately.
- Request logic, combinational:
  - IntReq = |(HWInt & IM) & IE & ~EXL.
  - ExcReq = (ExcCodeIn != 0) & ~EXL.
  - Req = IntReq | ExcReq.
  - Interrupt has priority over exception.
- Clock edge with Req=1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC - 4 : VPC (32-bit wrap; VPC=0 with BD gives 32'hFFFF_FFFC).
  - Any WE in the same cycle is dropped: the faulting instruction never commits.
- Clock edge with Req=0:
  - If WE and CP0Addr=12: SR <= CP0In masked to its defined bits.
  - If WE and CP0Addr=14: EPC <= CP0In.
  - WE to 13, 15 or any other address is ignored.
  - Then, if EXLClr: EXL <= 0. EXLClr wins over a same-cycle mtc0 to SR for the EXL bit only.
- Every edge, outside reset: Cause.IP <= HWInt (raw, unmasked, sampled).
- Read mux, combinational, no bypass:
  - 12 → SR; 13 → Cause; 14 → EPC; 15 → PRID; anything else → 0.
  - A read in the same cycle as a write returns the old value.
- Re-entry: while EXL=1 no Req is generated. ExcCodeIn is ignored, and interrupts stay pending in IP only.
- Latency:
  - Req is visible in the same cycle as its cause.
  - Register effects are visible one cycle after the edge.

Test Plan:
- Reset=1 with clk idle → CP0Out=0 for address 12/13/14, Req=0. Reading address 15 → 32'h2022_0707.
- WE=1, addr 12, data 32'h0000_FC01, then HWInt=6'b000100 → Req=1 immediately. After the edge: Cause=32'h0000_1000, EXL=1, EPC=VPC.
- ExcCodeIn=12 (ALU overflow), BDIn=1, VPC=32'h0000_3010 → Req=1. After the edge: Cause=32'h8000_0030, EPC=32'h0000_300C.
- Same cycle: ExcCodeIn=4, HWInt[0]=1 with IM[10]=IE=1, and WE to addr 14 → ExcCode=0, and EPC equals VPC, not CP0In.
- With EXL=1: ExcCodeIn=10 and HWInt=6'h3F → Req=0, IP=6'h3F. Then EXLClr=1 → EXL=0 next cycle, and Req reasserts if still pending.
- Assert reset asynchronously between edges while EXL=1 → SR=0 and Req=0 immediately, without waiting for a clock edge.
